// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the memory-access stage.
// Widths, ALU opcodes, stage state and the captured request.
package mem_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

  typedef enum logic {
    IDLE,
    BUSY
  } stage_state_e;

  typedef struct packed {
    word_t     addr;
    word_t     wdata;
    word_t     pc;
    reg_addr_t rd;
    logic      is_write;
    logic      reg_write;
    logic      mem_to_reg;
    logic      branch;
  } mem_req_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage.
// master drives the stage inputs, slave is the stage itself.
interface mem_stage_if;
  import mem_stage_pkg::*;

  word_t     result_in;
  word_t     store_data;
  reg_addr_t rd_in;
  logic      mem_read_in;
  logic      mem_write_in;
  logic      reg_write_in;
  logic      mem_to_reg_in;
  logic      branch_in;
  word_t     pc_in;

  word_t     read_data;
  word_t     alu_result_out;
  reg_addr_t rd_out;
  logic      reg_write_out;
  logic      mem_to_reg_out;
  logic      branch_out;
  word_t     pc_out;
  logic      stall_flag;
  logic      misalign_err;

  modport master (
    output result_in,
    output store_data,
    output rd_in,
    output mem_read_in,
    output mem_write_in,
    output reg_write_in,
    output mem_to_reg_in,
    output branch_in,
    output pc_in,
    input  read_data,
    input  alu_result_out,
    input  rd_out,
    input  reg_write_out,
    input  mem_to_reg_out,
    input  branch_out,
    input  pc_out,
    input  stall_flag,
    input  misalign_err
  );

  modport slave (
    input  result_in,
    input  store_data,
    input  rd_in,
    input  mem_read_in,
    input  mem_write_in,
    input  reg_write_in,
    input  mem_to_reg_in,
    input  branch_in,
    input  pc_in,
    output read_data,
    output alu_result_out,
    output rd_out,
    output reg_write_out,
    output mem_to_reg_out,
    output branch_out,
    output pc_out,
    output stall_flag,
    output misalign_err
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM, registered read.
// The array has no reset so contents survive a pipeline reset.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  word_t                    wdata,
  output word_t                    rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: MEM/WB register, multi-cycle data access,
// upstream stall and sticky misalignment flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  stage_state_e     state;
  stage_state_e     state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  mem_req_t in_req;
  mem_req_t held;
  mem_req_t cur;

  logic  mem_op;
  logic  accept;
  logic  done;
  logic  stall_go;
  logic  pass;
  logic  mis;
  logic  ram_en;
  logic  rd_zero;
  word_t rdata;

  word_t     alu_r;
  reg_addr_t rd_r;
  logic      rw_r;
  logic      m2r_r;
  logic      br_r;
  word_t     pc_r;
  logic      err_r;

  always_comb begin
    in_req = '{
      addr:       bus.result_in,
      wdata:      bus.store_data,
      pc:         bus.pc_in,
      rd:         bus.rd_in,
      is_write:   bus.mem_write_in,
      reg_write:  bus.reg_write_in,
      mem_to_reg: bus.mem_to_reg_in,
      branch:     bus.branch_in
    };
  end

  assign mem_op   = bus.mem_read_in | bus.mem_write_in;
  assign accept   = (state == IDLE) && mem_op;
  assign done     = (accept && (LAT == '0))
                  || ((state == BUSY) && (cnt == CNT_W'(1)));
  assign stall_go = accept && !done;
  assign pass     = (state == IDLE) && !mem_op;

  // In BUSY the upstream inputs are stale-held; use the captured copy.
  assign cur    = (state == BUSY) ? held : in_req;
  assign mis    = cur.addr[1:0] != 2'b00;
  assign ram_en = done && !mis && !reset;

  data_mem #(
    .DEPTH (DEPTH)
  ) u_data_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur.is_write),
    .addr  (cur.addr[AW+1:2]),
    .wdata (cur.wdata),
    .rdata (rdata)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (stall_go) begin
          state_nx = BUSY;
          cnt_nx   = LAT;
        end
      end
      BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (done) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held    <= '0;
      alu_r   <= '0;
      rd_r    <= '0;
      rw_r    <= 1'b0;
      m2r_r   <= 1'b0;
      br_r    <= 1'b0;
      pc_r    <= '0;
      err_r   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      if (accept) begin
        held <= in_req;
      end
      unique case (1'b1)
        done: begin
          alu_r   <= cur.addr;
          rd_r    <= cur.rd;
          rw_r    <= cur.reg_write;
          m2r_r   <= cur.mem_to_reg;
          br_r    <= cur.branch;
          pc_r    <= cur.pc;
          rd_zero <= cur.is_write | mis;
          if (mis) begin
            err_r <= 1'b1;
          end
        end
        stall_go: begin
          rw_r <= 1'b0;
          br_r <= 1'b0;
        end
        pass: begin
          alu_r <= in_req.addr;
          rd_r  <= in_req.rd;
          rw_r  <= in_req.reg_write;
          m2r_r <= in_req.mem_to_reg;
          br_r  <= in_req.branch;
          pc_r  <= in_req.pc;
        end
        default: begin
        end
      endcase
    end
  end

  // RAM output register only moves on aligned loads; rd_zero masks it.
  assign bus.read_data      = rd_zero ? '0 : rdata;
  assign bus.alu_result_out = alu_r;
  assign bus.rd_out         = rd_r;
  assign bus.reg_write_out  = rw_r;
  assign bus.mem_to_reg_out = m2r_r;
  assign bus.branch_out     = br_r;
  assign bus.pc_out         = pc_r;
  assign bus.stall_flag     = state == BUSY;
  assign bus.misalign_err   = err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage at latencies 2, 0 and 3.
// Driver pushes expected outputs tagged by cycle; monitor compares.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    word_t     a;
    word_t     wd;
    word_t     pc;
    reg_addr_t rd;
    logic      r;
    logic      w;
    logic      rw;
    logic      m2r;
    logic      br;
  } stim_t;

  typedef struct packed {
    word_t     rdata;
    word_t     alu;
    word_t     pc;
    reg_addr_t rd;
    logic      rw;
    logic      m2r;
    logic      br;
    logic      stall;
    logic      err;
  } obs_t;

  typedef struct {
    int    cyc;
    int    d;
    bit    full;
    obs_t  v;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  stim_t stim [3];
  word_t mdl [3][256];
  word_t rdv [3];
  logic  errm [3];
  exp_t  sbq [$];
  exp_t  mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_if b0 ();
  mem_stage_if b1 ();
  mem_stage_if b2 ();

  assign b0.result_in     = stim[0].a;
  assign b0.store_data    = stim[0].wd;
  assign b0.pc_in         = stim[0].pc;
  assign b0.rd_in         = stim[0].rd;
  assign b0.mem_read_in   = stim[0].r;
  assign b0.mem_write_in  = stim[0].w;
  assign b0.reg_write_in  = stim[0].rw;
  assign b0.mem_to_reg_in = stim[0].m2r;
  assign b0.branch_in     = stim[0].br;

  assign b1.result_in     = stim[1].a;
  assign b1.store_data    = stim[1].wd;
  assign b1.pc_in         = stim[1].pc;
  assign b1.rd_in         = stim[1].rd;
  assign b1.mem_read_in   = stim[1].r;
  assign b1.mem_write_in  = stim[1].w;
  assign b1.reg_write_in  = stim[1].rw;
  assign b1.mem_to_reg_in = stim[1].m2r;
  assign b1.branch_in     = stim[1].br;

  assign b2.result_in     = stim[2].a;
  assign b2.store_data    = stim[2].wd;
  assign b2.pc_in         = stim[2].pc;
  assign b2.rd_in         = stim[2].rd;
  assign b2.mem_read_in   = stim[2].r;
  assign b2.mem_write_in  = stim[2].w;
  assign b2.reg_write_in  = stim[2].rw;
  assign b2.mem_to_reg_in = stim[2].m2r;
  assign b2.branch_in     = stim[2].br;

  mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) u_l2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) u_l0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  mem_stage #(.DEPTH(256), .MEM_LATENCY(3)) u_l3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  function automatic int lat_of(int d);
    case (d)
      0: return 2;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic obs_t get_obs(int d);
    obs_t o;
    case (d)
      0: o = '{b0.read_data, b0.alu_result_out, b0.pc_out, b0.rd_out,
               b0.reg_write_out, b0.mem_to_reg_out, b0.branch_out,
               b0.stall_flag, b0.misalign_err};
      1: o = '{b1.read_data, b1.alu_result_out, b1.pc_out, b1.rd_out,
               b1.reg_write_out, b1.mem_to_reg_out, b1.branch_out,
               b1.stall_flag, b1.misalign_err};
      default: o = '{b2.read_data, b2.alu_result_out, b2.pc_out, b2.rd_out,
               b2.reg_write_out, b2.mem_to_reg_out, b2.branch_out,
               b2.stall_flag, b2.misalign_err};
    endcase
    return o;
  endfunction

  task automatic check(input exp_t e, input obs_t o);
    logic bad;
    checks++;
    if (e.full) bad = (o !== e.v);
    else bad = ({o.stall, o.rw, o.br} !== {e.v.stall, e.v.rw, e.v.br});
    if (bad) begin
      errors++;
      $display("FAIL %s dut%0d cyc%0d got %h want %h (rdata alu pc rd rw m2r br stall err)",
               e.nm, e.d, e.cyc, o, e.v);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mon_e = sbq.pop_front();
      check(mon_e, get_obs(mon_e.d));
    end
  end

  task automatic push(int c, int d, bit full, obs_t v, string nm);
    exp_t e;
    e.cyc  = c;
    e.d    = d;
    e.full = full;
    e.v    = v;
    e.nm   = nm;
    sbq.push_back(e);
  endtask

  task automatic issue(int d, bit r, bit w, word_t a, word_t wd,
                       reg_addr_t rd, bit rw, bit m2r, bit br,
                       word_t pc, string nm);
    int   lat;
    logic mis;
    obs_t v;
    stim[d] = '{a, wd, pc, rd, r, w, rw, m2r, br};
    lat = (r | w) ? lat_of(d) : 0;
    if (r | w) begin
      mis = a[1:0] != 2'b00;
      if (w) begin
        if (!mis) mdl[d][a[9:2]] = wd;
        rdv[d] = '0;
      end else begin
        rdv[d] = mis ? '0 : mdl[d][a[9:2]];
      end
      if (mis) errm[d] = 1'b1;
    end
    for (int i = 1; i <= lat; i++) begin
      v = '0;
      v.stall = 1'b1;
      push(cyc + i, d, 1'b0, v, {nm, "_stall"});
    end
    v = '{rdv[d], a, pc, rd, rw, m2r, br, 1'b0, errm[d]};
    push(cyc + 1 + lat, d, 1'b1, v, nm);
    repeat (1 + lat) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    obs_t v;
    for (int d = 0; d < 3; d++) begin
      stim[d] = '0;
      rdv[d]  = '0;
      errm[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) push(cyc + 1, d, 1'b1, '0, "reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(0, 0, 0, 32'h15, 0, 5'd3, 1, 0, 0, 0, "pass");
    issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0, "store");
    issue(0, 1, 0, 32'h10, 0, 5'd5, 1, 1, 0, 0, "load");
    issue(0, 0, 1, 32'h400, 32'hA5, 5'd0, 0, 0, 0, 0, "wrap_st");
    issue(0, 1, 0, 32'h0, 0, 5'd6, 1, 1, 0, 0, "wrap_ld");
    issue(0, 1, 1, 32'h24, 32'hCAFEF00D, 5'd0, 0, 0, 0, 0, "rw_both");
    issue(0, 1, 0, 32'h24, 0, 5'd8, 1, 1, 0, 0, "both_ld");
    issue(0, 1, 0, 32'h13, 0, 5'd4, 1, 1, 0, 0, "mis_ld");
    issue(0, 0, 1, 32'h11, 32'hFFFFFFFF, 5'd0, 0, 0, 0, 0, "mis_st");
    issue(0, 1, 0, 32'h10, 0, 5'd5, 1, 1, 0, 0, "unchanged");
    issue(0, 0, 0, 32'h77, 0, 5'd7, 1, 0, 1, 32'h100, "hold_rd");
    issue(0, 0, 1, 32'h20, 32'h5555AAAA, 5'd0, 0, 0, 0, 0, "pre_st");
    stim[0] = '0;

    issue(1, 0, 0, 32'h0, 0, 5'd0, 0, 0, 1, 32'h40, "br_l0");
    issue(1, 0, 1, 32'h8, 32'h77, 5'd0, 0, 0, 0, 0, "st_l0");
    issue(1, 1, 0, 32'h8, 0, 5'd9, 1, 1, 0, 0, "ld_l0");
    stim[1] = '0;

    issue(2, 0, 1, 32'hC, 32'h99, 5'd0, 0, 0, 0, 0, "st_l3");
    issue(2, 1, 0, 32'hC, 0, 5'd10, 1, 1, 1, 32'h80, "br_ld_l3");
    stim[2] = '0;
    repeat (2) @(negedge clk);

    stim[0] = '{32'h20, 32'h1234, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    v = '0;
    v.stall = 1'b1;
    push(cyc + 1, 0, 1'b0, v, "rst_st_stall");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stim[0] = '0;
    for (int d = 0; d < 3; d++) begin
      rdv[d]  = '0;
      errm[d] = 1'b0;
      push(cyc + 1, d, 1'b1, '0, "mid_reset");
    end
    @(negedge clk);
    reset = 1'b0;
    issue(0, 1, 0, 32'h20, 0, 5'd11, 1, 1, 0, 0, "old_val");
    stim[0] = '0;

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
